// File: rtl/mem_port_arbiter_if.sv
// Client request/response and memory strobe signals shared by the arbiter and its environment.
// The bidirectional data bus is kept as a separate module port.
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE = 16
);
    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic [WORD_SIZE-1:0] i_rdata;
    logic                 i_done;

    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 d_done;

    logic                 err;

    logic                 readM;
    logic                 writeM;
    logic [WORD_SIZE-1:0] address;
    logic                 inputReady;
    logic                 ackOutput;

    // Arbiter side: masters the memory port, serves both clients.
    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, inputReady, ackOutput,
        output i_rdata, i_done, d_rdata, d_done, err, readM, writeM, address
    );

    // Environment side: clients plus memory model.
    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, inputReady, ackOutput,
        input  i_rdata, i_done, d_rdata, d_done, err, readM, writeM, address
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch (I) and data access (D).
// D has priority; a streak counter forces an I grant after STARVE_LIMIT back-to-back D grants.
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mem_port_arbiter_if.master   bus,
    inout  logic [WORD_SIZE-1:0] data
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX  = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TCOUNT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t               state_q, state_n;
    logic                 grant_d_q, grant_d_n;
    logic                 we_q, we_n;
    logic [WORD_SIZE-1:0] wdata_q, wdata_n;
    logic [SW-1:0]        streak_q, streak_n;
    logic [TW-1:0]        tcount_q, tcount_n;
    logic                 readM_q, readM_n;
    logic                 writeM_q, writeM_n;
    logic [WORD_SIZE-1:0] address_q, address_n;
    logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_n;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_n;
    logic                 i_done_q, i_done_n;
    logic                 d_done_q, d_done_n;
    logic                 err_q, err_n;
    logic                 pick_d;
    logic                 finish;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_d_q <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            streak_q  <= '0;
            tcount_q  <= '0;
            readM_q   <= 1'b0;
            writeM_q  <= 1'b0;
            address_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            grant_d_q <= grant_d_n;
            we_q      <= we_n;
            wdata_q   <= wdata_n;
            streak_q  <= streak_n;
            tcount_q  <= tcount_n;
            readM_q   <= readM_n;
            writeM_q  <= writeM_n;
            address_q <= address_n;
            i_rdata_q <= i_rdata_n;
            d_rdata_q <= d_rdata_n;
            i_done_q  <= i_done_n;
            d_done_q  <= d_done_n;
            err_q     <= err_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        grant_d_n = grant_d_q;
        we_n      = we_q;
        wdata_n   = wdata_q;
        streak_n  = streak_q;
        tcount_n  = tcount_q;
        readM_n   = readM_q;
        writeM_n  = writeM_q;
        address_n = address_q;
        i_rdata_n = i_rdata_q;
        d_rdata_n = d_rdata_q;
        i_done_n  = 1'b0;
        d_done_n  = 1'b0;
        err_n     = 1'b0;
        pick_d    = 1'b0;
        finish    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    pick_d    = bus.d_req && !(bus.i_req && (streak_q == STREAK_MAX));
                    grant_d_n = pick_d;
                    tcount_n  = '0;
                    state_n   = ACCESS;
                    if (pick_d) begin
                        we_n      = bus.d_we;
                        address_n = bus.d_addr;
                        wdata_n   = bus.d_wdata;
                        readM_n   = !bus.d_we;
                        writeM_n  = bus.d_we;
                        if (!bus.i_req) begin
                            streak_n = '0;
                        end else if (streak_q != STREAK_MAX) begin
                            streak_n = streak_q + 1'b1;
                        end
                    end else begin
                        we_n      = 1'b0;
                        address_n = bus.i_addr;
                        readM_n   = 1'b1;
                        writeM_n  = 1'b0;
                        streak_n  = '0;
                    end
                end
            end

            ACCESS: begin
                // Only the ack matching the active strobe type can complete the access.
                if (!we_q && bus.inputReady) begin
                    readM_n = 1'b0;
                    finish  = 1'b1;
                    if (grant_d_q) begin
                        d_rdata_n = data;
                    end else begin
                        i_rdata_n = data;
                    end
                end else if (we_q && bus.ackOutput) begin
                    writeM_n = 1'b0;
                    finish   = 1'b1;
                end else if (tcount_q == TCOUNT_LAST) begin
                    readM_n  = 1'b0;
                    writeM_n = 1'b0;
                    err_n    = 1'b1;
                    finish   = 1'b1;
                end else begin
                    tcount_n = tcount_q + 1'b1;
                end

                if (finish) begin
                    state_n  = DONE;
                    d_done_n = grant_d_q;
                    i_done_n = !grant_d_q;
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign data = writeM_q ? wdata_q : 'z;

    assign bus.readM   = readM_q;
    assign bus.writeM  = writeM_q;
    assign bus.address = address_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_done  = i_done_q;
    assign bus.d_done  = d_done_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle vector table plus hand-written
// sequences for arbitration order, timeout and mid-access reset.
module tb_mem_port_arbiter;
    logic clk;
    logic reset_n;
    wire  [15:0] data;

    mem_port_arbiter_if #(.WORD_SIZE(16)) bus ();

    mem_port_arbiter #(
        .WORD_SIZE   (16),
        .STARVE_LIMIT(3),
        .TIMEOUT     (15)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .data   (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: drives data while readM is high, stores on a write ack edge.
    logic [15:0] mem [0:255];
    assign data = bus.readM ? mem[bus.address[7:0]] : 'z;
    always @(posedge clk) begin
        if (bus.writeM && bus.ackOutput) mem[bus.address[7:0]] <= data;
    end

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [15:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [15:0] daddr;
        logic [15:0] dwdata;
        logic        irdy;
        logic        ack;
        logic        e_rd;
        logic        e_wr;
        logic [15:0] e_addr;
        logic        e_idone;
        logic        e_ddone;
        logic        e_err;
        logic [15:0] e_irdata;
        logic [15:0] e_drdata;
        logic        e_datachk;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int total;
    int bad;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {11'b0, bus.readM, bus.writeM, bus.address, bus.i_done, bus.d_done,
                bus.err, bus.i_rdata, bus.d_rdata};
    endfunction

    function automatic logic [63:0] exp_outs(input vec_t v);
        return {11'b0, v.e_rd, v.e_wr, v.e_addr, v.e_idone, v.e_ddone,
                v.e_err, v.e_irdata, v.e_drdata};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic exp_d [8];
    int   idle;
    int   hi;
    logic seen;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        mem[8'h00] <= 16'h430a;
        mem[8'h20] <= 16'h0000;
        mem[8'h21] <= 16'h1234;
        mem[8'h30] <= 16'h5555;
        mem[8'h40] <= 16'ha040;
        mem[8'h50] <= 16'hb050;
        mem[8'h60] <= 16'hc060;
        mem[8'h70] <= 16'h0000;

        exp_d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        //          rst  ireq  iaddr    dreq dwe  daddr    dwdata   irdy ack | rd  wr   addr     idn  ddn  err  irdata   drdata   dchk
        vecs[0]  = '{1'b0,1'b1,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0, 1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0};
        vecs[1]  = '{1'b0,1'b1,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0, 1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0};
        vecs[2]  = '{1'b1,1'b1,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0, 1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0};
        vecs[3]  = '{1'b1,1'b1,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0, 1'b0,1'b0,16'h0000,1'b1,1'b0,1'b0,16'h430a,16'h0000,1'b0};
        vecs[4]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0, 1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h430a,16'h0000,1'b0};
        vecs[5]  = '{1'b1,1'b0,16'h0000,1'b1,1'b1,16'h0020,16'h000a,1'b0,1'b0, 1'b0,1'b1,16'h0020,1'b0,1'b0,1'b0,16'h430a,16'h0000,1'b1};
        vecs[6]  = '{1'b1,1'b0,16'h0000,1'b1,1'b1,16'h0020,16'h000a,1'b0,1'b0, 1'b0,1'b1,16'h0020,1'b0,1'b0,1'b0,16'h430a,16'h0000,1'b1};
        vecs[7]  = '{1'b1,1'b0,16'h0000,1'b1,1'b1,16'h0020,16'h000a,1'b0,1'b1, 1'b0,1'b0,16'h0020,1'b0,1'b1,1'b0,16'h430a,16'h0000,1'b0};
        vecs[8]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0020,16'h000a,1'b0,1'b0, 1'b0,1'b0,16'h0020,1'b0,1'b0,1'b0,16'h430a,16'h0000,1'b0};
        vecs[9]  = '{1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0021,16'h0000,1'b0,1'b0, 1'b1,1'b0,16'h0021,1'b0,1'b0,1'b0,16'h430a,16'h0000,1'b0};
        vecs[10] = '{1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0030,16'h0000,1'b0,1'b1, 1'b1,1'b0,16'h0021,1'b0,1'b0,1'b0,16'h430a,16'h0000,1'b0};
        vecs[11] = '{1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0030,16'h0000,1'b1,1'b0, 1'b0,1'b0,16'h0021,1'b0,1'b1,1'b0,16'h430a,16'h1234,1'b0};
        vecs[12] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0030,16'h0000,1'b0,1'b0, 1'b0,1'b0,16'h0021,1'b0,1'b0,1'b0,16'h430a,16'h1234,1'b0};

        reset_n        = 1'b0;
        bus.i_req      = 1'b0;
        bus.i_addr     = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.inputReady = 1'b0;
        bus.ackOutput  = 1'b0;

        for (int v = 0; v < NV; v++) begin
            reset_n        = vecs[v].rst;
            bus.i_req      = vecs[v].ireq;
            bus.i_addr     = vecs[v].iaddr;
            bus.d_req      = vecs[v].dreq;
            bus.d_we       = vecs[v].dwe;
            bus.d_addr     = vecs[v].daddr;
            bus.d_wdata    = vecs[v].dwdata;
            bus.inputReady = vecs[v].irdy;
            bus.ackOutput  = vecs[v].ack;
            step();
            check($sformatf("vec%0d", v), outs(), exp_outs(vecs[v]));
            if (vecs[v].e_datachk) check($sformatf("vec%0d_data", v), {48'b0, data}, {48'b0, vecs[v].dwdata});
        end
        check("mem_write_0x20", {48'b0, mem[8'h20]}, 64'h000a);

        // Both clients requesting continuously: expect D,D,D,I,D,D,D,I.
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0040;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'h0050;
        for (int g = 0; g < 8; g++) begin
            idle = 0;
            seen = 1'b0;
            for (int c = 0; c < 10; c++) begin
                step();
                if (bus.readM) begin
                    seen = 1'b1;
                    break;
                end
                idle++;
            end
            check($sformatf("arb%0d_start", g), {63'b0, seen}, 64'd1);
            if (!seen) break;
            check($sformatf("arb%0d_grant", g), {48'b0, bus.address}, exp_d[g] ? 64'h0050 : 64'h0040);
            if (g > 0) check($sformatf("arb%0d_gap", g), {63'b0, (idle >= 1)}, 64'd1);
            bus.inputReady = 1'b1;
            step();
            bus.inputReady = 1'b0;
            check($sformatf("arb%0d_done", g), {60'b0, bus.readM, bus.i_done, bus.d_done, bus.err},
                  exp_d[g] ? 64'b0010 : 64'b0100);
            check($sformatf("arb%0d_rdata", g), exp_d[g] ? {48'b0, bus.d_rdata} : {48'b0, bus.i_rdata},
                  exp_d[g] ? 64'hb050 : 64'ha040);
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        step();

        // Read that is never acknowledged: readM high exactly 15 cycles, then done+err.
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'h0060;
        hi = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (!bus.readM) break;
            hi++;
        end
        check("timeout_len", 64'(hi), 64'd15);
        check("timeout_done", {43'b0, bus.readM, bus.writeM, bus.i_done, bus.d_done, bus.err, bus.d_rdata},
              {43'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hb050});
        bus.d_req = 1'b0;
        step();
        check("timeout_after", {61'b0, bus.d_done, bus.i_done, bus.err}, 64'd0);

        // Reset in the second ACCESS cycle of a write.
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h0070;
        bus.d_wdata = 16'h7777;
        step();
        check("rst_mid_wr1", {63'b0, bus.writeM}, 64'd1);
        step();
        check("rst_mid_wr2", {63'b0, bus.writeM}, 64'd1);
        reset_n   = 1'b0;
        bus.d_req = 1'b0;
        step();
        check("rst_mid_outs", outs(), 64'd0);
        reset_n = 1'b1;
        step();
        check("rst_mid_idle", outs(), 64'd0);
        check("rst_mid_nomem", {48'b0, mem[8'h70]}, 64'h0000);
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0000;
        step();
        check("rst_fresh_start", {46'b0, bus.readM, bus.writeM, bus.address}, {46'b0, 1'b1, 1'b0, 16'h0000});
        bus.inputReady = 1'b1;
        step();
        bus.inputReady = 1'b0;
        bus.i_req      = 1'b0;
        check("rst_fresh_done", {45'b0, bus.readM, bus.i_done, bus.err, bus.i_rdata},
              {45'b0, 1'b0, 1'b1, 1'b0, 16'h430a});
        step();
        check("rst_fresh_after", {62'b0, bus.i_done, bus.readM}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
